// File: rtl/serial_tx_ctrl.sv
// LSB-first parallel-to-serial transmitter: one word per DW*CLK_DIV+2 cycles, strobe on the last cycle of each bit.
// ready_out is high only in IDLE; inputs are ignored while a word is shifting or in the done cycle.
module serial_tx_ctrl #(
  parameter int DW      = 4,
  parameter int CLK_DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_in,
  input  logic          valid_in,
  output logic          ready_out,
  output logic          ser_out,
  output logic          ser_enb,
  output logic          busy,
  output logic          done
);

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BCW  = $clog2(DW + 1);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [BCW-1:0]  BIT_LAST = BCW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   shreg;
  logic [BCW-1:0]  bit_cnt;
  logic [DIVW-1:0] div_cnt;
  logic            accept;
  logic            strobe;

  assign accept = (state == IDLE) && valid_in;
  assign strobe = (state == SHIFT) && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (strobe && (bit_cnt == BIT_LAST)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The shift happens on the strobe edge, so shreg[0] stays put for the whole bit period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (accept) begin
      shreg   <= data_in;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (state == SHIFT) begin
      if (strobe) begin
        shreg   <= shreg >> 1;
        bit_cnt <= bit_cnt + BCW'(1);
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIVW'(1);
      end
    end
  end

  always_comb begin
    ready_out = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    ser_enb   = 1'b0;
    ser_out   = 1'b0;
    case (state)
      IDLE:  ready_out = 1'b1;
      SHIFT: begin
        busy    = 1'b1;
        ser_enb = strobe;
        ser_out = shreg[0];
      end
      DONE:  done = 1'b1;
      default: ready_out = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// Bench for serial_tx_ctrl: four instances (DW/CLK_DIV = 4/4, 4/3, 4/1, 8/1) each feeding a modelled sipo.
module tb_serial_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] d_in [4];
  logic       v_in [4];
  logic       rdy  [4];
  logic       sout [4];
  logic       enb  [4];
  logic       bsy  [4];
  logic       dn   [4];

  logic [7:0] sipo    [4] = '{default: 8'h00};
  int         strobes [4] = '{default: 0};
  int         dones   [4] = '{default: 0};

  int total = 0;
  int bad   = 0;

  function automatic int dw_of(input int k);
    return (k == 3) ? 8 : 4;
  endfunction

  function automatic int cd_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 3 : 1;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int W = (g == 3) ? 8 : 4;
    localparam int C = (g == 0) ? 4 : (g == 1) ? 3 : 1;
    serial_tx_ctrl #(.DW(W), .CLK_DIV(C)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (d_in[g][W-1:0]),
      .valid_in  (v_in[g]),
      .ready_out (rdy[g]),
      .ser_out   (sout[g]),
      .ser_enb   (enb[g]),
      .busy      (bsy[g]),
      .done      (dn[g])
    );
  end

  // Downstream sipo model: shifts ser_out in at the MSB on every strobe, so the
  // first (LSB) bit ends up lowest after DW strobes.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (enb[k] === 1'b1) begin
        sipo[k]    <= {sout[k], sipo[k][7:1]};
        strobes[k] <= strobes[k] + 1;
      end
      if (dn[k] === 1'b1) dones[k] <= dones[k] + 1;
    end
  end

  // Called at a negedge with inputs already set; returns just after the accept edge.
  task automatic wait_accept(input int k, output int waits);
    waits = 0;
    while (rdy[k] !== 1'b1 && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (rdy[k] !== 1'b1) begin
      total++; bad++;
      $display("FAIL accept_timeout k=%0d ready=%b want=1", k, rdy[k]);
    end
    @(posedge clk);
  endtask

  // Checks one word against the expected timeline from cycle 0 to the cycle ready returns.
  task automatic check_word(input int k, input logic [7:0] w, input logic nxt_v,
                            input logic [7:0] nxt_d, input bit scramble);
    int dw, cd, n, s0;
    logic e_enb, e_out;
    logic [7:0] got_w, want_w;
    dw = dw_of(k);
    cd = cd_of(k);
    n  = dw * cd;
    s0 = strobes[k];
    for (int c = 0; c <= n + 1; c++) begin
      @(negedge clk);
      e_enb = (c < n) && (((c + 1) % cd) == 0);
      e_out = (c < n) ? w[c / cd] : 1'b0;
      total++;
      if (enb[k] !== e_enb) begin
        bad++; $display("FAIL ser_enb k=%0d c=%0d got=%b want=%b", k, c, enb[k], e_enb);
      end
      total++;
      if (sout[k] !== e_out) begin
        bad++; $display("FAIL ser_out k=%0d c=%0d got=%b want=%b", k, c, sout[k], e_out);
      end
      total++;
      if (dn[k] !== (c == n)) begin
        bad++; $display("FAIL done k=%0d c=%0d got=%b want=%b", k, c, dn[k], (c == n));
      end
      total++;
      if (bsy[k] !== (c < n)) begin
        bad++; $display("FAIL busy k=%0d c=%0d got=%b want=%b", k, c, bsy[k], (c < n));
      end
      total++;
      if (rdy[k] !== (c == n + 1)) begin
        bad++; $display("FAIL ready k=%0d c=%0d got=%b want=%b", k, c, rdy[k], (c == n + 1));
      end
      if (c == n) begin
        got_w  = sipo[k] >> (8 - dw);
        want_w = w & ((8'h01 << dw) - 8'h01);
        total++;
        if (got_w !== want_w) begin
          bad++; $display("FAIL sipo_word k=%0d got=%h want=%h", k, got_w, want_w);
        end
        total++;
        if (strobes[k] - s0 != dw) begin
          bad++; $display("FAIL strobe_count k=%0d got=%0d want=%0d", k, strobes[k] - s0, dw);
        end
      end
      if (scramble) begin
        d_in[k] = 8'($urandom);
        v_in[k] = (c <= n) ? 1'($urandom_range(0, 1)) : 1'b0;
      end else if (c == 0) begin
        d_in[k] = nxt_d;
        v_in[k] = nxt_v;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rdy[k] !== 1'b1 || enb[k] !== 1'b0 || sout[k] !== 1'b0 || bsy[k] !== 1'b0 || dn[k] !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs k=%0d got rdy=%b enb=%b out=%b busy=%b done=%b want 1 0 0 0 0",
                 k, rdy[k], enb[k], sout[k], bsy[k], dn[k]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (rdy[k] !== 1'b1 || bsy[k] !== 1'b0) begin
        bad++; $display("FAIL idle_after_reset k=%0d got rdy=%b busy=%b want 1 0", k, rdy[k], bsy[k]);
      end
    end
  endtask

  task automatic test_single();
    int waits;
    d_in[0] = 8'h0B; v_in[0] = 1'b1;
    wait_accept(0, waits);
    check_word(0, 8'h0B, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    int waits, s0;
    s0 = strobes[0];
    d_in[0] = 8'h0B; v_in[0] = 1'b1;
    wait_accept(0, waits);
    check_word(0, 8'h0B, 1'b1, 8'h06, 1'b0);
    wait_accept(0, waits);
    total++;
    if (waits != 0) begin
      bad++; $display("FAIL b2b_second_accept got_wait=%0d want=0", waits);
    end
    check_word(0, 8'h06, 1'b0, 8'h00, 1'b0);
    total++;
    if (strobes[0] - s0 != 8) begin
      bad++; $display("FAIL b2b_strobes got=%0d want=8", strobes[0] - s0);
    end
  endtask

  task automatic test_ignore_midword();
    int waits;
    d_in[0] = 8'h0A; v_in[0] = 1'b1;
    wait_accept(0, waits);
    check_word(0, 8'h0A, 1'b1, 8'h05, 1'b0);
    wait_accept(0, waits);
    check_word(0, 8'h05, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_midword();
    int waits, s0, d0;
    d_in[0] = 8'h0F; v_in[0] = 1'b1;
    wait_accept(0, waits);
    s0 = strobes[0];
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      v_in[0] = 1'b0;
    end
    total++;
    if (strobes[0] - s0 != 2 || sout[0] !== 1'b1 || bsy[0] !== 1'b1) begin
      bad++; $display("FAIL pre_reset_state got strobes=%0d out=%b busy=%b want 2 1 1",
                      strobes[0] - s0, sout[0], bsy[0]);
    end
    d0 = dones[0];
    rst = 1'b0;
    #1;
    total++;
    if (rdy[0] !== 1'b1 || enb[0] !== 1'b0 || sout[0] !== 1'b0 || bsy[0] !== 1'b0 || dn[0] !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got rdy=%b enb=%b out=%b busy=%b done=%b want 1 0 0 0 0",
               rdy[0], enb[0], sout[0], bsy[0], dn[0]);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (dones[0] != d0 || rdy[0] !== 1'b1) begin
      bad++; $display("FAIL no_done_after_reset got dones=%0d rdy=%b want %0d 1", dones[0], rdy[0], d0);
    end
    d_in[0] = 8'h03; v_in[0] = 1'b1;
    wait_accept(0, waits);
    check_word(0, 8'h03, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_div1_wide();
    int waits;
    d_in[3] = 8'hC5; v_in[3] = 1'b1;
    wait_accept(3, waits);
    check_word(3, 8'hC5, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    int waits, gap;
    logic [7:0] w;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 200; i++) begin
        gap = $urandom_range(0, 3);
        v_in[k] = 1'b0;
        for (int j = 0; j < gap; j++) begin
          d_in[k] = 8'($urandom);
          @(negedge clk);
        end
        w = 8'($urandom_range(0, 15));
        d_in[k] = w; v_in[k] = 1'b1;
        wait_accept(k, waits);
        check_word(k, w, 1'b0, 8'h00, 1'b1);
      end
      v_in[k] = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d_in[k] = 8'h00;
      v_in[k] = 1'b0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_midword();
    test_reset_midword();
    test_div1_wide();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_tx_ctrl.md
Name: serial_tx_ctrl

Overview:
Parallel-to-serial transmit controller feeding the sipo deserializer directly upstream. It accepts a DW-bit word over a valid/ready handshake and emits it LSB-first on a serial line. Each bit gets a one-cycle enable strobe, paced by a programmable clock divider. With ser_out wired to sipo.inp and ser_enb wired to sipo.enb (same DW), the sipo holds exactly the transmitted word after the DW-th strobe.

Parameters:
DW, 4, word width in bits; must be >= 2.
CLK_DIV, 4, clock cycles per serial bit; must be >= 1.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-low
data_in  input  DW  word to transmit; sampled only on handshake
valid_in  input  1  data_in is valid
ready_out  output  1  block can accept a word this cycle
ser_out  output  1  serial data, LSB first; drives sipo.inp
ser_enb  output  1  one-cycle bit strobe; drives sipo.enb
busy  output  1  a word is being shifted
done  output  1  one-cycle pulse after the last bit strobe

Behaviour:
- One clock (clk); reset rst is asynchronous and active-low. While rst=0: state=IDLE, shift register=0, bit and divider counters=0, ser_out=0, ser_enb=0, busy=0, done=0, ready_out=1.
- FSM states:
  - IDLE: ready_out=1. A handshake (valid_in & ready_out at a rising edge) loads data_in into the shift register, clears both counters, and moves to SHIFT.
  - SHIFT: ready_out=0, busy=1.
  - DONE: lasts exactly one cycle; done=1, ready_out=0, busy=0; then IDLE.
- Divider counter div_cnt counts 0..CLK_DIV-1 in SHIFT and wraps to 0.
- ser_enb = (state==SHIFT) & (div_cnt==CLK_DIV-1). It is combinational from registered state; never glitch-driven by inputs.
- ser_out = shreg[0] in SHIFT and 0 otherwise. It is stable for the full CLK_DIV cycles of each bit, including the strobe cycle.
- On each strobe edge: shreg shifts right by 1 (zero fill) and bit_cnt increments. The edge of the DW-th strobe moves SHIFT to DONE.
- Timing, with cycle 0 = first cycle after the accept edge:
  - ser_enb high in cycles (i+1)*CLK_DIV-1, for i=0..DW-1.
  - done high in cycle DW*CLK_DIV.
  - ready_out high again in cycle DW*CLK_DIV+1.
  - Minimum word period is DW*CLK_DIV+2 cycles, including the accept cycle.
- CLK_DIV=1: ser_enb is continuously high during SHIFT; one bit per cycle.
- data_in and valid_in are ignored outside IDLE. Changing data_in mid-word has no effect on the word being sent.
- valid_in held high continuously gives back-to-back words: the next accept occurs in the IDLE cycle right after DONE.
- No word is dropped: a word is transmitted iff a handshake occurred.
- Reset mid-word: the word is abandoned immediately and no done pulse is emitted. After release, the block is in IDLE with ready_out=1.
- Counter widths: bit_cnt holds 0..DW; div_cnt holds 0..CLK_DIV-1 (minimum 1 bit). There is no overflow path.

Test Plan:
- DW=4, CLK_DIV=4, send 4'hB once:
  - ser_out bits are 1,1,0,1.
  - ser_enb is high in cycles 3,7,11,15; done is high in cycle 16; ready_out returns in cycle 17.
  - A connected sipo then reads 4'hB.
- valid_in held high with data 4'hB then 4'h6:
  - Second accept occurs in cycle 17.
  - The sipo reads 4'h6 after the second done; exactly 8 strobes in total.
- Accept 4'hA, then drive data_in=4'h5 with valid_in=1 during SHIFT:
  - ser_out still sends 0,1,0,1 and the sipo reads 4'hA.
  - 4'h5 is accepted only after done.
- Assert rst=0 after 2 strobes of 4'hF:
  - All outputs go to reset values asynchronously (ready_out=1) and no done pulse occurs.
  - A fresh 4'h3 then transmits correctly.
- CLK_DIV=1, DW=8, send 8'hC5:
  - ser_enb is high in cycles 0..7 and ser_out is 1,0,1,0,0,0,1,1; done is high in cycle 8.
  - A sipo with DW=8 reads 8'hC5.
- Random data, 200 words, random valid_in gaps, for CLK_DIV in {1,3,4}:
  - The sipo word after every done equals the accepted word.
  - Strobe count per word is exactly DW.
